// File: rtl/pwm_duty_meter.sv
// pwm_duty_meter: measures high time and period of an incoming PWM line,
// reports a 0..10 duty step through a 4-iteration restoring divider, and
// flags a line that has been stuck high or low for TIMEOUT cycles.
module pwm_duty_meter #(
   parameter int CNT_W   = 16,
   parameter int TIMEOUT = 1000
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             pwm_in,
   output logic [CNT_W-1:0] high_cnt,
   output logic [CNT_W-1:0] period_cnt,
   output logic [3:0]       duty_step,
   output logic             meas_valid,
   output logic             stuck_high,
   output logic             stuck_low
);

   localparam int               DW        = CNT_W + 4;
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_W'(1);
      end
   endfunction

   logic             s1_r, s2_r, s3_r;
   logic             rise_s, fall_s, edge_s;
   logic [CNT_W-1:0] idle_cnt_r;
   logic             timeout_s;
   state_t           state_r, state_next_s;
   logic             capture_s;
   logic [CNT_W-1:0] cnt_r, h_r;
   logic             busy_r;
   logic [1:0]       iter_r;
   logic [DW-1:0]    num_r;
   logic [CNT_W-1:0] den_r;
   logic [3:0]       q_r;
   logic [CNT_W-1:0] hold_h_r, hold_p_r;
   logic [DW-1:0]    shifted_s;
   logic [DW-1:0]    ten_h_s;
   logic             ge_s;
   logic             done_s;
   logic [3:0]       q_final_s;

   assign rise_s    = s2_r & ~s3_r;
   assign fall_s    = ~s2_r & s3_r;
   assign edge_s    = rise_s | fall_s;
   // Fires exactly once per edge-free span, TIMEOUT+1 cycles after the last edge.
   assign timeout_s = (idle_cnt_r == IDLE_LAST) && !edge_s;

   assign ten_h_s   = (DW'(h_r) << 2'd3) + (DW'(h_r) << 1'b1);
   assign shifted_s = DW'(den_r) << iter_r;
   assign ge_s      = (num_r >= shifted_s);
   // Final iteration lands on the same edge as the report, so bit 0 comes straight from the compare.
   assign done_s    = busy_r && (iter_r == 2'd0) && !timeout_s;
   assign q_final_s = q_r | {3'b000, ge_s};

   // Two-stage synchronizer plus one history stage for edge detection.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
         s3_r <= 1'b0;
      end else begin
         s1_r <= pwm_in;
         s2_r <= s1_r;
         s3_r <= s2_r;
      end
   end

   // Cycles since the last edge of either polarity, saturating.
   always_ff @(posedge clk) begin
      if (rst) begin
         idle_cnt_r <= '0;
      end else if (edge_s) begin
         idle_cnt_r <= '0;
      end else begin
         idle_cnt_r <= sat_inc(idle_cnt_r);
      end
   end

   // Measurement FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Measurement FSM next state and period-capture strobe; timeout forces IDLE.
   always_comb begin
      state_next_s = state_r;
      capture_s    = 1'b0;
      if (timeout_s) begin
         state_next_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (rise_s) begin
                  state_next_s = ST_HIGH;
               end else begin
                  state_next_s = ST_IDLE;
               end
            end
            ST_HIGH: begin
               if (fall_s) begin
                  state_next_s = ST_LOW;
               end else begin
                  state_next_s = ST_HIGH;
               end
            end
            ST_LOW: begin
               if (rise_s) begin
                  state_next_s = ST_HIGH;
                  capture_s    = 1'b1;
               end else begin
                  state_next_s = ST_LOW;
               end
            end
            default: begin
               state_next_s = ST_IDLE;
            end
         endcase
      end
   end

   // Period counter and latched high time.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= '0;
         h_r   <= '0;
      end else if (timeout_s) begin
         cnt_r <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (rise_s) begin
                  cnt_r <= CNT_W'(1);
               end
            end
            ST_HIGH: begin
               cnt_r <= sat_inc(cnt_r);
               if (fall_s) begin
                  h_r <= cnt_r;
               end
            end
            ST_LOW: begin
               if (rise_s) begin
                  cnt_r <= CNT_W'(1);
               end else begin
                  cnt_r <= sat_inc(cnt_r);
               end
            end
            default: begin
               cnt_r <= '0;
            end
         endcase
      end
   end

   // Restoring divider: 10*h / P, quotient bits 3 down to 0; captures while busy are dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy_r   <= 1'b0;
         iter_r   <= 2'd0;
         num_r    <= '0;
         den_r    <= '0;
         q_r      <= 4'd0;
         hold_h_r <= '0;
         hold_p_r <= '0;
      end else if (timeout_s) begin
         busy_r <= 1'b0;
      end else if (busy_r) begin
         if (ge_s) begin
            num_r <= num_r - shifted_s;
         end
         q_r[iter_r] <= ge_s;
         if (iter_r == 2'd0) begin
            busy_r <= 1'b0;
         end else begin
            iter_r <= iter_r - 2'd1;
         end
      end else if (capture_s) begin
         busy_r   <= 1'b1;
         iter_r   <= 2'd3;
         num_r    <= ten_h_s;
         den_r    <= cnt_r;
         q_r      <= 4'd0;
         hold_h_r <= h_r;
         hold_p_r <= cnt_r;
      end
   end

   // Registered outputs: a timeout report overrides a division completing in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         high_cnt   <= '0;
         period_cnt <= '0;
         duty_step  <= 4'd0;
         meas_valid <= 1'b0;
         stuck_high <= 1'b0;
         stuck_low  <= 1'b0;
      end else if (timeout_s) begin
         high_cnt   <= '0;
         period_cnt <= '0;
         duty_step  <= s2_r ? 4'd10 : 4'd0;
         meas_valid <= 1'b1;
         stuck_high <= s2_r;
         stuck_low  <= ~s2_r;
      end else begin
         meas_valid <= done_s;
         if (done_s) begin
            high_cnt   <= hold_h_r;
            period_cnt <= hold_p_r;
            duty_step  <= q_final_s;
         end
         if (rise_s) begin
            stuck_high <= 1'b0;
            stuck_low  <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_duty_meter.sv
// Self-checking bench for pwm_duty_meter: event-level reference model
// (edge times, periods, plain integer division) compared every cycle.
module tb_pwm_duty_meter;

   localparam int CNT_W   = 16;
   localparam int TIMEOUT = 1000;

   logic             clk;
   logic             rst;
   logic             pwm_in;
   logic [CNT_W-1:0] high_cnt;
   logic [CNT_W-1:0] period_cnt;
   logic [3:0]       duty_step;
   logic             meas_valid;
   logic             stuck_high;
   logic             stuck_low;

   pwm_duty_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .pwm_in     (pwm_in),
      .high_cnt   (high_cnt),
      .period_cnt (period_cnt),
      .duty_step  (duty_step),
      .meas_valid (meas_valid),
      .stuck_high (stuck_high),
      .stuck_low  (stuck_low)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // Reference model: synchronizer image plus edge-time bookkeeping.
   logic m_s1, m_s2, m_s3;
   int   last_edge, open_rise, fall_t, busy_until, cap_t;
   bit   have_fall, pend;
   int   pend_due, pend_h, pend_p, pend_d;
   int   e_high, e_period, e_duty;
   bit   e_mv, e_sh, e_sl;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic model_reset();
      m_s1 = 1'b0; m_s2 = 1'b0; m_s3 = 1'b0;
      last_edge = cyc; open_rise = -1; fall_t = 0; have_fall = 0;
      busy_until = 0; pend = 0;
      e_high = 0; e_period = 0; e_duty = 0; e_mv = 0; e_sh = 0; e_sl = 0;
   endtask

   // Evaluate the end of cycle 'cyc'; leaves expected outputs for cycle cyc+1.
   task automatic model_step(input logic pv, input logic rv);
      bit rise, fall;
      int per, hi;
      if (rv) begin
         model_reset();
      end else begin
         rise = m_s2 && !m_s3;
         fall = !m_s2 && m_s3;
         e_mv = 0;
         if (!rise && !fall && (cyc - last_edge == TIMEOUT)) begin
            e_sh = m_s2; e_sl = !m_s2;
            e_duty = m_s2 ? 10 : 0;
            e_high = 0; e_period = 0; e_mv = 1;
            open_rise = -1; pend = 0; busy_until = 0;
         end else begin
            if (pend && pend_due == cyc + 1) begin
               e_high = pend_h; e_period = pend_p; e_duty = pend_d; e_mv = 1;
               pend = 0;
            end
            if (rise) begin
               e_sh = 0; e_sl = 0;
               if (open_rise >= 0 && have_fall) begin
                  per = cyc - open_rise;
                  hi  = fall_t - open_rise;
                  if (cyc >= busy_until) begin
                     pend = 1; pend_due = cyc + 5;
                     pend_h = hi; pend_p = per; pend_d = (10 * hi) / per;
                     busy_until = cyc + 5;
                     cap_t = cyc;
                  end
               end
               open_rise = cyc;
               have_fall = 0;
            end
            if (fall && open_rise >= 0) begin
               fall_t = cyc;
               have_fall = 1;
            end
         end
         if (rise || fall) last_edge = cyc;
         m_s3 = m_s2; m_s2 = m_s1; m_s1 = pv;
      end
   endtask

   // Drive one cycle of inputs, step the model, compare after the clock edge.
   task automatic run_cycle(input logic pv, input logic rv);
      pwm_in = pv;
      rst    = rv;
      model_step(pv, rv);
      @(posedge clk);
      @(negedge clk);
      cyc++;
      check("meas_valid", 32'(meas_valid), 32'(e_mv));
      check("stuck_high", 32'(stuck_high), 32'(e_sh));
      check("stuck_low",  32'(stuck_low),  32'(e_sl));
      check("high_cnt",   32'(high_cnt),   32'(e_high));
      check("period_cnt", 32'(period_cnt), 32'(e_period));
      check("duty_step",  32'(duty_step),  32'(e_duty));
   endtask

   task automatic periods(input int h, input int l, input int n);
      for (int k = 0; k < n; k++) begin
         for (int j = 0; j < h; j++) run_cycle(1'b1, 1'b0);
         for (int j = 0; j < l; j++) run_cycle(1'b0, 1'b0);
      end
   endtask

   task automatic hold(input logic v, input int n);
      for (int j = 0; j < n; j++) run_cycle(v, 1'b0);
   endtask

   initial begin
      int start_cap;
      rst    = 1'b1;
      pwm_in = 1'b0;
      cap_t  = -100;
      model_reset();

      // Reset with the input toggling.
      for (int i = 0; i < 3; i++) run_cycle(i[0], 1'b1);

      // 50% loopback, duty sweep at P=10, and P=7/H=3.
      periods(5, 5, 8);
      periods(1, 9, 4);
      periods(3, 7, 4);
      periods(9, 1, 4);
      periods(3, 4, 4);

      // Stuck high, recovery, stuck low, recovery.
      hold(1'b1, 1100);
      periods(5, 5, 4);
      hold(1'b0, 1100);
      periods(5, 5, 4);

      // Short period: some captures dropped while the divider is busy.
      periods(1, 2, 20);

      // Reset two cycles after a closing rise, while the division is in flight.
      periods(5, 5, 3);
      start_cap = cap_t;
      for (int g = 0; g < 30; g++) begin
         if (cap_t != start_cap && cyc == cap_t + 2) break;
         run_cycle(((g / 5) % 2) == 0, 1'b0);
      end
      for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1);
      periods(5, 5, 3);

      // Random periods, then random per-cycle noise.
      for (int i = 0; i < 40; i++) begin
         periods(int'($urandom_range(1, 12)), int'($urandom_range(1, 12)), 1);
      end
      for (int i = 0; i < 300; i++) run_cycle(1'($urandom_range(0, 1)), 1'b0);
      hold(1'b0, 20);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm_duty_meter.md
# pwm_duty_meter

Receive-side companion to the PWM generator. Measures an incoming PWM waveform, reports high time and period in clock cycles, and converts the ratio to a 10%-step duty value (0–10). Flags a stuck-high or stuck-low line when no edges arrive. Sits on the board-side input path, so a generated PWM can be looped back and checked, or an external PWM source can be read.

## Interface
Parameters:
- CNT_W, 16: width of the high-time and period counters.
- TIMEOUT, 1000: cycles with no edge of either polarity before a stuck flag is raised. Constraint: 2 ≤ TIMEOUT ≤ 2^CNT_W − 1.

Ports:
- clk  in  1  system clock (100 MHz)
- rst  in  1  reset; synchronous, active-high
- pwm_in  in  1  PWM input, asynchronous to clk
- high_cnt  out  CNT_W  high time of the last completed period, in cycles
- period_cnt  out  CNT_W  length of the last completed period, in cycles
- duty_step  out  4  floor(10·high_cnt/period_cnt), range 0–10
- meas_valid  out  1  one-cycle pulse when the outputs above update
- stuck_high  out  1  line held high for ≥ TIMEOUT cycles
- stuck_low  out  1  line held low for ≥ TIMEOUT cycles

## Operation
- Input path:
  - 2-FF synchronizer (s1, s2), then a history FF s3.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - No glitch filtering.
- Measurement FSM states: IDLE, HIGH, LOW.
  - IDLE: wait for a rise. On rise, go to HIGH and set cnt = 1. This first partial period is never reported.
  - HIGH: cnt increments each cycle. On fall, latch h = cnt and go to LOW.
  - LOW: cnt increments each cycle. On rise, capture (h, P = cnt) to the divider if it is idle, set cnt = 1, and go to HIGH.
- Divider:
  - Fixed 4-iteration restoring division of N = 10·h by D = P, producing quotient bits 3 down to 0.
  - Iteration i: if N ≥ D<<i, then N −= D<<i and q[i] = 1.
  - Internal width is CNT_W+4 bits, so there is no overflow.
  - When it finishes, high_cnt ← h, period_cnt ← P, duty_step ← q, and meas_valid pulses.
  - A capture that arrives while the divider is busy is dropped silently. The FSM still restarts cnt.
- Timeout:
  - idle_cnt resets to 0 on any rise or fall and otherwise increments, saturating.
  - When idle_cnt reaches TIMEOUT:
    - If s2 = 1: stuck_high ← 1, duty_step ← 10.
    - If s2 = 0: stuck_low ← 1, duty_step ← 0.
    - In both cases: high_cnt ← 0, period_cnt ← 0, meas_valid pulses once, the FSM goes to IDLE, and any in-flight division is aborted.
  - Both stuck flags clear on the next rise. The next report follows only after one full subsequent period.
- Simultaneous events:
  - A timeout and a divider completion in the same cycle: the timeout wins and the division result is discarded.
  - rise and fall cannot occur in the same cycle.
- Counter saturation: cnt saturates at 2^CNT_W − 1. The constraint on TIMEOUT guarantees the timeout fires first on any edge-free span.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and the divider is idle. Reset mid-period or mid-division discards all partial state.
- Input latency: pwm_in to rise/fall detection is 2–3 clk cycles (synchronizer).
- Report latency: let T be the cycle in which rise closes a period. The divider iterates in T+1..T+4. The outputs update and meas_valid is high in cycle T+5, for exactly one cycle.
- Period definition: period_cnt = cycles between successive rise detections. high_cnt = cycles from a rise detection to the next fall detection.
- Throughput: one report per period for P ≥ 5. For P < 5, some periods are dropped, but every reported value is self-consistent.
- Timeout latency: the stuck flag and meas_valid assert in the cycle after idle_cnt reaches TIMEOUT, i.e. TIMEOUT+1 cycles after the last edge detection.

## Test plan
- Reset: hold rst for 3 cycles with pwm_in toggling. All outputs are 0 during reset and the cycle after, and no meas_valid appears before two rises have been detected after reset.
- 50% loopback: pwm_in high 5 / low 5 cycles, repeating. The first meas_valid comes 5 cycles after the second detected rise, with high_cnt = 5, period_cnt = 10, duty_step = 5. After that, one meas_valid every 10 cycles with identical values.
- Duty sweep at P = 10 with high = 1, 3, 9: duty_step = 1, 3, 9 respectively. Also P = 7, H = 3: duty_step = 4, high_cnt = 3, period_cnt = 7.
- Stuck high: with TIMEOUT = 1000, hold pwm_in high after a valid stream. stuck_high = 1, duty_step = 10, high_cnt = period_cnt = 0, and exactly one meas_valid. Resume 5/5 toggling: stuck_high clears at the first rise, then a normal 5/10/5 report follows one period later. Repeat holding low: stuck_low = 1, duty_step = 0.
- Short period: P = 3, H = 1. Reports arrive no more often than once every 5 cycles, each showing high_cnt = 1, period_cnt = 3, duty_step = 3, with no corrupted values.
- Reset mid-division: assert rst in cycle T+2 after a closing rise. No meas_valid follows and the outputs stay 0 until a full new period is measured.
